fifo_byte_packer: RTL and testbench
===================================

Name: fifo_byte_packer

Overview:
- Downstream consumer of the team's byte FIFO.
- Drains 8-bit entries from the FIFO and packs PACK_COUNT consecutive bytes, little-endian, into one wide word.
- Presents each word on a valid/ready output port for the wide datapath or bus master.
- A flush input releases a partially filled word.

Parameters:
- DATA_WIDTH, 8: width of one FIFO entry.
- PACK_COUNT, 4: bytes per output word; legal range 2..16.
- CNT_WIDTH, 16: width of the words_sent status counter.
- TIMEOUT_CYCLES, 64: idle cycles before an auto-flush; used only with PACKER_TIMEOUT_FLUSH_EN.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  empty flag from the upstream FIFO.
- fifo_data  input  DATA_WIDTH  FIFO head entry; valid in the same cycle whenever fifo_empty=0.
- fifo_rd_en  output  1  pop request to the FIFO; combinational.
- flush  input  1  single-cycle request to emit a partial word.
- out_data  output  DATA_WIDTH*PACK_COUNT  packed word.
- out_keep  output  PACK_COUNT  per-lane valid mask.
- out_valid  output  1  word available.
- out_ready  input  1  sink accepts the word.
- words_sent  output  CNT_WIDTH  count of completed output handshakes; saturating.

Behaviour:
- Reset is asynchronous, active-high; the block runs on clk.
- Reset values: state=FILL, byte_cnt=0, out_valid=0, out_data=0, out_keep=0, words_sent=0. fifo_rd_en=0 while reset is high.
- States: FILL, HOLD.
- fifo_rd_en = (state==FILL) && !fifo_empty && !reset. A byte is accepted on every clk edge where fifo_rd_en=1.
- Accepted byte is written to lane byte_cnt, i.e. out_data[byte_cnt*DATA_WIDTH +: DATA_WIDTH]; out_keep[byte_cnt] is set; byte_cnt increments.
- Lane 0 holds the first byte popped.
- FILL -> HOLD when a byte is accepted with byte_cnt==PACK_COUNT-1. out_valid=1 on the next cycle; out_keep is all ones.
- FILL -> HOLD on flush=1 when byte_cnt>0 or a byte is accepted in the same cycle. That same-cycle byte is included in the word.
  - Unfilled lanes read 0 and have keep=0.
- flush with no bytes held and none accepted is ignored; no output is produced.
- flush while in HOLD is ignored; it is not queued.
- HOLD: fifo_rd_en=0; out_data and out_keep are stable; out_valid stays 1 until out_ready=1.
- Handshake on a cycle with out_valid && out_ready:
  - next cycle: out_valid=0, out_data=0, out_keep=0, byte_cnt=0, state=FILL;
  - words_sent increments, saturating at all ones.
- A one-cycle bubble follows every handshake. Peak throughput is one word per PACK_COUNT+1 cycles.
- out_valid never deasserts without a handshake except on reset.
- Reset mid-word discards the partial bytes; popped bytes are not restored.
- Reset with out_valid=1 drops the word.
- Latency: the last byte popped at edge N gives out_valid=1 from edge N onward. The word is visible in the cycle after edge N.

Optional Feature:
- Macro: PACKER_TIMEOUT_FLUSH_EN.
- Defined:
  - An idle counter of ceil(log2(TIMEOUT_CYCLES+1)) bits runs in FILL while byte_cnt>0 and no byte is accepted.
  - The counter clears on any accept, on a transition to HOLD, and on reset.
  - When the count reaches TIMEOUT_CYCLES, the block behaves exactly as an internal flush pulse in that cycle; the counter then clears.
- Undefined: no counter; partial words leave only via the flush input.
- All other behaviour is identical with or without the macro.

Test Plan:
- Basic pack: FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> fifo_rd_en high 4 cycles; out_data=0x44332211, out_keep=4'b1111, one-cycle out_valid; words_sent=1.
- Backpressure: 8 bytes 0x01..0x08, out_ready=0 for 10 cycles after the first word -> out_data=0x04030201 held stable; fifo_rd_en=0 throughout; after out_ready=1, second word is 0x08070605; words_sent=2.
- Partial flush: bytes 0xAA,0xBB then FIFO empty, flush pulse -> out_data=0x0000BBAA, out_keep=4'b0011; flush with zero bytes held -> no out_valid.
- Flush with a same-cycle accept: byte 0xCC accepted while flush=1 and byte_cnt=1 (0x10 held) -> out_data=0x0000CC10, out_keep=4'b0011.
- Reset mid-word: 3 bytes accepted, reset asserted asynchronously mid-cycle -> out_valid=0, out_keep=0, words_sent=0 immediately; next 4 bytes 0x01..0x04 give 0x04030201.
- PACKER_TIMEOUT_FLUSH_EN, TIMEOUT_CYCLES=8: single byte 0x5A, FIFO stays empty -> out_valid rises after 8 idle cycles with out_data=0x0000005A, out_keep=4'b0001. Without the macro, out_valid stays 0 indefinitely.

Source files
------------

// File: rtl/fifo_byte_packer.sv
// rtl/fifo_byte_packer.sv - drains a byte FIFO and packs PACK_COUNT bytes little-endian into valid/ready words
// Optional idle auto-flush: define PACKER_TIMEOUT_FLUSH_EN.
module fifo_byte_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_COUNT     = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic [DATA_WIDTH*PACK_COUNT-1:0] out_data,
  output logic [PACK_COUNT-1:0]            out_keep,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CNT_WIDTH-1:0]             words_sent
);

  localparam int BCW = (PACK_COUNT > 1) ? $clog2(PACK_COUNT) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                            r_state;
  logic [BCW-1:0]                    r_byte_cnt;
  logic [DATA_WIDTH*PACK_COUNT-1:0]  r_out_data;
  logic [PACK_COUNT-1:0]             r_out_keep;
  logic                              r_out_valid;
  logic [CNT_WIDTH-1:0]              r_words_sent;

  logic w_accept;
  logic w_last;
  logic w_timeout;
  logic w_flush_go;

  generate
    if (PACK_COUNT < 2 || PACK_COUNT > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("fifo_byte_packer: PACK_COUNT must be 2..16 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  // Internal accept omits reset so reset never feeds flop data paths; the flops are held by reset anyway.
  assign w_accept   = (r_state == FILL) && !fifo_empty;
  assign fifo_rd_en = w_accept && !reset;
  assign w_last     = w_accept && (r_byte_cnt == BCW'(PACK_COUNT - 1));
  assign w_flush_go = (r_state == FILL) && (flush || w_timeout) && ((r_byte_cnt != '0) || w_accept);

`ifdef PACKER_TIMEOUT_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_idle_cnt;

  assign w_timeout = (r_idle_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt <= '0;
    end else if ((r_state != FILL) || w_accept || w_flush_go) begin
      r_idle_cnt <= '0;
    end else if (r_byte_cnt != '0) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FILL;
      r_byte_cnt   <= '0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_valid  <= 1'b0;
      r_words_sent <= '0;
    end else if (r_state == FILL) begin
      if (w_accept) begin
        for (int i = 0; i < PACK_COUNT; i++) begin
          if (r_byte_cnt == BCW'(i)) begin
            r_out_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
            r_out_keep[i]                          <= 1'b1;
          end
        end
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      if (w_last || w_flush_go) begin
        r_state     <= HOLD;
        r_out_valid <= 1'b1;
      end
    end else begin
      // Word is frozen until accepted; flush requests here are dropped.
      if (out_ready) begin
        r_state     <= FILL;
        r_byte_cnt  <= '0;
        r_out_data  <= '0;
        r_out_keep  <= '0;
        r_out_valid <= 1'b0;
        if (r_words_sent != {CNT_WIDTH{1'b1}}) begin
          r_words_sent <= r_words_sent + 1'b1;
        end
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_keep   = r_out_keep;
  assign out_valid  = r_out_valid;
  assign words_sent = r_words_sent;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// tb/tb_fifo_byte_packer.sv - directed scoreboard bench for fifo_byte_packer
module tb_fifo_byte_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        flush;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] words_sent;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
  } word_t;

  logic [7:0] fq[$];
  word_t      sb[$];
  int         checks = 0;
  int         errors = 0;
  int         rd_cnt;
  int         v_cnt;
  int         exp_words = 0;
  int         n;

  fifo_byte_packer #(
    .DATA_WIDTH(8), .PACK_COUNT(4), .CNT_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .flush(flush), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fifo_upd();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fq[0];
  endtask

  task automatic load(input logic [7:0] b);
    fq.push_back(b);
    fifo_upd();
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    word_t w;
    w.d = d;
    w.k = k;
    sb.push_back(w);
  endtask

  // One clock: sample pre-edge, update the FIFO model and check handshakes just after the edge.
  task automatic step();
    logic        rd, hs;
    logic [31:0] hd;
    logic [3:0]  hk;
    word_t       w;
    #1;
    rd = fifo_rd_en;
    hs = out_valid && out_ready;
    hd = out_data;
    hk = out_keep;
    @(posedge clk);
    #1;
    if (rd) begin
      rd_cnt++;
      if (fq.size() != 0) void'(fq.pop_front());
      fifo_upd();
    end
    if (out_valid) v_cnt++;
    if (hs) begin
      exp_words++;
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'd1, 32'd0);
      end else begin
        w = sb.pop_front();
        chk("word_data", hd, w.d);
        chk("word_keep", {28'd0, hk}, {28'd0, w.k});
      end
    end
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) step();
    chk({"drain_", tag}, sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    fifo_upd();
    #3;
    load(8'h99);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_keep", {28'd0, out_keep}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_words", {16'd0, words_sent}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    step();
    chk("rst_rd_en_edge", {31'd0, fifo_rd_en}, 32'd0);
    void'(fq.pop_front());
    fifo_upd();
    reset = 1'b0;

    // Basic pack
    out_ready = 1'b1;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    expect_word(32'h44332211, 4'hF);
    rd_cnt = 0;
    v_cnt  = 0;
    for (int i = 0; i < 4; i++) step();
    chk("basic_latency_valid", {31'd0, out_valid}, 32'd1);
    step();
    step();
    chk("basic_rd_cycles", rd_cnt, 4);
    chk("basic_valid_cycles", v_cnt, 1);
    chk("basic_words", {16'd0, words_sent}, 32'd1);

    // Backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) load(8'(i));
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    for (int i = 0; i < 4; i++) step();
    chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", out_data, 32'h04030201);
      chk("bp_hold_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    end
    out_ready = 1'b1;
    drain("bp", 20);
    chk("bp_words", {16'd0, words_sent}, 32'd3);

    // Partial flush
    load(8'hAA); load(8'hBB);
    step(); step();
    chk("pf_no_valid", {31'd0, out_valid}, 32'd0);
    expect_word(32'h0000BBAA, 4'h3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("pf_valid", {31'd0, out_valid}, 32'd1);
    chk("pf_data", out_data, 32'h0000BBAA);
    chk("pf_keep", {28'd0, out_keep}, 32'h3);
    step();
    step();
    v_cnt = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pf_empty_flush_ignored", v_cnt, 0);

    // Flush with same-cycle accept
    load(8'h10);
    step();
    load(8'hCC);
    expect_word(32'h0000CC10, 4'h3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sc_valid", {31'd0, out_valid}, 32'd1);
    chk("sc_data", out_data, 32'h0000CC10);
    chk("sc_keep", {28'd0, out_keep}, 32'h3);
    drain("sc", 4);
    chk("sc_words", {16'd0, words_sent}, exp_words);

    // Reset mid-word
    load(8'hE1); load(8'hE2); load(8'hE3);
    step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    exp_words = 0;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_keep", {28'd0, out_keep}, 32'd0);
    chk("mr_data", out_data, 32'd0);
    chk("mr_words", {16'd0, words_sent}, 32'd0);
    #2;
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) load(8'(i));
    expect_word(32'h04030201, 4'hF);
    drain("mr", 20);
    chk("mr_words_after", {16'd0, words_sent}, 32'd1);

    // Idle timeout
    load(8'h5A);
    step();
    expect_word(32'h0000005A, 4'h1);
`ifdef PACKER_TIMEOUT_FLUSH_EN
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    chk("to_idle_cycles", n, 9);
    chk("to_data", out_data, 32'h0000005A);
    chk("to_keep", {28'd0, out_keep}, 32'h1);
    drain("to", 4);
`else
    v_cnt = 0;
    for (int i = 0; i < 100; i++) step();
    chk("to_disabled_no_valid", v_cnt, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("to_manual_data", out_data, 32'h0000005A);
    drain("to", 4);
`endif

    chk("final_sb_empty", sb.size(), 0);
    chk("final_words", {16'd0, words_sent}, exp_words);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
